// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// Shared encodings for the mul/div dispatch front-end: request function codes,
// divider signedness codes and the dispatch FSM states.
package imuldiv_muldiv_dispatch_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    localparam logic DIVFN_SIGNED   = 1'b0;
    localparam logic DIVFN_UNSIGNED = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic fn_is_legal(input logic [2:0] fn);
        return (fn <= FN_REMU);
    endfunction

    function automatic logic fn_is_mul(input logic [2:0] fn);
        return (fn == FN_MUL);
    endfunction

    function automatic logic fn_is_rem(input logic [2:0] fn);
        return (fn == FN_REM) || (fn == FN_REMU);
    endfunction

    function automatic logic divfn_of(input logic [2:0] fn);
        return ((fn == FN_DIVU) || (fn == FN_REMU)) ? DIVFN_UNSIGNED : DIVFN_SIGNED;
    endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_ctrl.sv
// Dispatch FSM: upstream/downstream handshakes and datapath load strobes.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready for a new request
//   ST_ISSUE | presenting registered operands to the target unit
//   ST_WAIT  | waiting for the target unit's response
//   ST_RESP  | presenting the registered result to the pipeline
//
// Every handshake output is a function of state and the registered fn only,
// so no input val/rdy reaches an output combinationally.
module imuldiv_muldiv_dispatch_ctrl
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       muldivreq_val,
    input  logic [2:0] muldivreq_fn,
    input  logic [2:0] fn_reg,
    input  logic       mulreq_rdy,
    input  logic       divreq_rdy,
    input  logic       mulresp_val,
    input  logic       divresp_val,
    input  logic       muldivresp_rdy,
    output logic       muldivreq_rdy,
    output logic       mulreq_val,
    output logic       divreq_val,
    output logic       mulresp_rdy,
    output logic       divresp_rdy,
    output logic       muldivresp_val,
    output logic       load_req,
    output logic       load_err,
    output logic       load_resp
);

    state_t state;
    state_t state_next;
    logic   target_mul;

    assign target_mul = fn_is_mul(fn_reg);

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake outputs and datapath strobes.
    always_comb begin
        state_next     = state;
        muldivreq_rdy  = 1'b0;
        mulreq_val     = 1'b0;
        divreq_val     = 1'b0;
        mulresp_rdy    = 1'b0;
        divresp_rdy    = 1'b0;
        muldivresp_val = 1'b0;
        load_req       = 1'b0;
        load_err       = 1'b0;
        load_resp      = 1'b0;
        case (state)
            ST_IDLE: begin
                muldivreq_rdy = 1'b1;
                if (muldivreq_val) begin
                    load_req = 1'b1;
                    if (fn_is_legal(muldivreq_fn)) begin
                        state_next = ST_ISSUE;
                    end else begin
                        load_err   = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if (target_mul) begin
                    mulreq_val = 1'b1;
                    if (mulreq_rdy) state_next = ST_WAIT;
                end else begin
                    divreq_val = 1'b1;
                    if (divreq_rdy) state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mulresp_rdy = target_mul;
                divresp_rdy = !target_mul;
                if (target_mul ? mulresp_val : divresp_val) begin
                    load_resp  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                muldivresp_val = 1'b1;
                if (muldivresp_rdy) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/imuldiv_muldiv_dispatch_datapath.sv
// Request register, result select and result/err registers.
module imuldiv_muldiv_dispatch_datapath
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic        load_err,
    input  logic        load_resp,
    input  logic [2:0]  req_fn,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [63:0] mul_result,
    input  logic [63:0] div_result,
    output logic [2:0]  fn_reg,
    output logic [31:0] a_reg,
    output logic [31:0] b_reg,
    output logic [31:0] result,
    output logic        err
);

    logic [31:0] resp_sel;
    logic        unused_mul_hi;

    // Only the low product word is ever returned to the pipeline.
    assign unused_mul_hi = ^mul_result[63:32];

    // Pick the result word for the operation in flight.
    always_comb begin
        resp_sel = div_result[31:0];
        if (fn_is_mul(fn_reg)) begin
            resp_sel = mul_result[31:0];
        end else if (fn_is_rem(fn_reg)) begin
            resp_sel = div_result[63:32];
        end
    end

    // Request register, held from accept until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn_reg <= '0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (load_req) begin
            fn_reg <= req_fn;
            a_reg  <= req_a;
            b_reg  <= req_b;
        end
    end

    // Result/err registers; an illegal fn short-circuits to a zero result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            err    <= 1'b0;
        end else if (load_err) begin
            result <= '0;
            err    <= 1'b1;
        end else if (load_resp) begin
            result <= resp_sel;
            err    <= 1'b0;
        end
    end

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// Mul/div front-end: decodes one request, issues it to the multiplier or
// divider, and returns the selected 32-bit result in order.
module imuldiv_muldiv_dispatch
    import imuldiv_muldiv_dispatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,
    output logic [31:0] muldivresp_msg_result,
    output logic        muldivresp_msg_err,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,
    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,
    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,
    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,
    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy
);

    logic [2:0]  fn_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        load_req;
    logic        load_err;
    logic        load_resp;

    imuldiv_muldiv_dispatch_ctrl u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .muldivreq_val  (muldivreq_val),
        .muldivreq_fn   (muldivreq_msg_fn),
        .fn_reg         (fn_reg),
        .mulreq_rdy     (mulreq_rdy),
        .divreq_rdy     (divreq_rdy),
        .mulresp_val    (mulresp_val),
        .divresp_val    (divresp_val),
        .muldivresp_rdy (muldivresp_rdy),
        .muldivreq_rdy  (muldivreq_rdy),
        .mulreq_val     (mulreq_val),
        .divreq_val     (divreq_val),
        .mulresp_rdy    (mulresp_rdy),
        .divresp_rdy    (divresp_rdy),
        .muldivresp_val (muldivresp_val),
        .load_req       (load_req),
        .load_err       (load_err),
        .load_resp      (load_resp)
    );

    imuldiv_muldiv_dispatch_datapath u_dp (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .load_err   (load_err),
        .load_resp  (load_resp),
        .req_fn     (muldivreq_msg_fn),
        .req_a      (muldivreq_msg_a),
        .req_b      (muldivreq_msg_b),
        .mul_result (mulresp_msg_result),
        .div_result (divresp_msg_result),
        .fn_reg     (fn_reg),
        .a_reg      (a_reg),
        .b_reg      (b_reg),
        .result     (muldivresp_msg_result),
        .err        (muldivresp_msg_err)
    );

    // Both units see the registered operands; only the target gets req_val.
    assign mulreq_msg_a  = a_reg;
    assign mulreq_msg_b  = b_reg;
    assign divreq_msg_a  = a_reg;
    assign divreq_msg_b  = b_reg;
    assign divreq_msg_fn = divfn_of(fn_reg);

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
# imuldiv_muldiv_dispatch

Front-end of the iterative mul/div unit. Accepts one 3-bit-function mul/div request, decodes it, issues it to either the multiplier or the divider request port, and collects that unit's 64-bit response. It then returns one selected 32-bit result to the pipeline. Only one operation is in flight at a time, and responses are strictly in order.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- muldivreq_msg_fn  in  3  0=MUL, 1=DIV, 2=DIVU, 3=REM, 4=REMU; 5–7 illegal
- muldivreq_msg_a, muldivreq_msg_b  in  32 each  operands
- muldivreq_val  in  1 / muldivreq_rdy  out  1  upstream request handshake
- muldivresp_msg_result  out  32  selected result
- muldivresp_msg_err  out  1  illegal-function flag
- muldivresp_val  out  1 / muldivresp_rdy  in  1  upstream response handshake
- mulreq_msg_a, mulreq_msg_b  out  32 each; mulreq_val  out  1; mulreq_rdy  in  1
- mulresp_msg_result  in  64; mulresp_val  in  1; mulresp_rdy  out  1
- divreq_msg_fn  out  1  0=signed, 1=unsigned; divreq_msg_a, divreq_msg_b  out  32 each; divreq_val  out  1; divreq_rdy  in  1
- divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}; divresp_val  in  1; divresp_rdy  out  1

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - muldivreq_rdy=1.
  - On val&&rdy: capture fn, a and b into the request register, then go to ISSUE. If fn is illegal, load result=0 and err=1 instead and go to RESP.
- ISSUE
  - Asserts the target unit's req_val with the registered operands. MUL goes to the mul port; DIV, DIVU, REM and REMU go to the div port.
  - divreq_msg_fn=1 for DIVU/REMU, 0 otherwise.
  - The non-target req_val stays 0.
  - On target req_val&&req_rdy, go to WAIT.
  - Operands and fn stay stable while req_val=1.
- WAIT
  - Target resp_rdy=1; the non-target resp_rdy=0.
  - On target resp_val, capture the result and go to RESP:
    - MUL → mul[31:0]
    - DIV/DIVU → div[31:0]
    - REM/REMU → div[63:32]
  - err=0.
- RESP
  - muldivresp_val=1 with the registered result and err.
  - On muldivresp_rdy, go to IDLE.
  - No new request is accepted in this cycle.
- A resp_val from the non-target unit, or any resp_val outside WAIT, is ignored and never acknowledged.
- All outputs in states not listed above are 0.

## Timing
- Reset (asynchronous assert, clocked release):
  - State=IDLE; all val/rdy outputs 0 except muldivreq_rdy=1.
  - Result, err and the request register are 0.
  - Reset asserted mid-operation abandons the operation and drops req_val/resp_rdy within the reset.
- muldivreq_rdy, all req_val, all resp_rdy and muldivresp_val are decoded from state only. There is no combinational path from any input val/rdy to any output.
- Minimum latency, request accept to muldivresp_val, is 3 cycles plus sub-unit latency:
  - accept at edge 0;
  - ISSUE cycle 1, handshake there;
  - WAIT from cycle 2, response captured at the resp_val edge;
  - RESP on the following cycle.
- Back-to-back requests are spaced at least 4 cycles apart, since IDLE follows RESP.
- Backpressure: a low req_rdy holds ISSUE indefinitely; a low muldivresp_rdy holds RESP with stable outputs.

## Structure
- Shared package/include holds:
  - the muldivreq fn encodings (MUL/DIV/DIVU/REM/REMU);
  - the divreq fn encodings (SIGNED=0, UNSIGNED=1);
  - the state encodings.
- Split into imuldiv_muldiv_dispatch_ctrl (FSM, val/rdy, selects) and datapath (request register, result mux, result/err registers).

## Test plan
- MUL a=3, b=0xFFFFFFFC; mul stub returns 0xFFFFFFFF_FFFFFFF4 after 5 cycles → result 0xFFFFFFF4, err=0. divreq_val never asserted.
- DIV a=0xFFFFFFF9, b=2; div stub returns {0xFFFFFFFF, 0xFFFFFFFD} → divreq_msg_fn=0, result 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU a=0xFFFFFFFF, b=2; stub returns {1, 0x7FFFFFFF} → divreq_msg_fn=1, result 0x7FFFFFFF. REMU → 0x00000001.
- fn=6 → muldivresp_val in the cycle after accept, result 0, err=1. No mul or div req_val ever asserted.
- Backpressure: divreq_rdy low for 4 cycles, then muldivresp_rdy low for 3 cycles → divreq operands and the result held stable, and muldivreq_rdy stays 0 throughout.
- reset asserted in WAIT → outputs reach reset values immediately. A new MUL after release completes correctly, and the stale div resp_val is ignored.
